// File: rtl/xram_arbiter.sv
// Round-robin burst arbiter for the single-port XRAM: grants whole bursts atomically,
// sequences beat addresses and routes read data back to the owning requester.
`timescale 1ns/1ps
module xram_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         beat_ack,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, ptr_q, pick, cand;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beat_q, last_q;
  logic [CNT_W-1:0]  dcnt_q;
  logic              drain_end_c;
  logic              tag_v_q  [RD_LAT];
  logic [ID_W-1:0]   tag_id_q [RD_LAT];

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [LEN_W-1:0]  len_a   [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]   = req_len[i*LEN_W +: LEN_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Round-robin pick: first set request after ptr; scanning backwards leaves the nearest one.
  always_comb begin
    pick = ptr_q;
    cand = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % int'(N_REQ));
      if (req[cand]) pick = cand;
    end
  end

  // Writes drain in one cycle; reads wait for the last beat's data to return.
  assign drain_end_c = we_q || (dcnt_q == CNT_W'(RD_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_BURST;
      S_BURST: if (beat_q == last_q) state_d = S_DRAIN;
      S_DRAIN: if (drain_end_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      ptr_q  <= ID_W'(N_REQ - 1);
      we_q   <= 1'b0;
      addr_q <= '0;
      beat_q <= '0;
      last_q <= '0;
      dcnt_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= (state_q == S_BURST) && !we_q;
      tag_id_q[0] <= id_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            id_q   <= pick;
            ptr_q  <= pick;
            we_q   <= req_we[pick];
            addr_q <= addr_a[pick];
            beat_q <= '0;
            if (len_a[pick] == '0) last_q <= '0;
            else                   last_q <= len_a[pick] - LEN_W'(1);
          end
        end
        S_BURST: begin
          beat_q <= beat_q + LEN_W'(1);
          dcnt_q <= CNT_W'(1);
        end
        S_DRAIN: dcnt_q <= dcnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decode straight from flops so reset clears them immediately.
  always_comb begin
    gnt       = '0;
    beat_ack  = '0;
    rvalid    = '0;
    done      = '0;
    rdata     = '0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = (state_q != S_IDLE);
    if (state_q != S_IDLE) gnt[id_q] = 1'b1;
    if (state_q == S_BURST) begin
      ram_en         = 1'b1;
      ram_we         = we_q;
      ram_addr       = addr_q + ADDR_W'(beat_q);
      ram_wdata      = wdata_a[id_q];
      beat_ack[id_q] = 1'b1;
    end
    if ((state_q == S_DRAIN) && drain_end_c) done[id_q] = 1'b1;
    if (tag_v_q[RD_LAT-1]) begin
      rvalid[tag_id_q[RD_LAT-1]] = 1'b1;
      rdata                      = ram_rdata;
    end
  end

endmodule
